// File: rtl/mips_boot_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package mips_boot_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_LOAD  = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERROR = 3'd5
    } state_t;

    localparam int HDR_BYTES      = 4;
    localparam int BYTES_PER_WORD = 4;
    localparam int ADDR_SHIFT     = 2;

endpackage

// File: rtl/imem_boot_loader_byte_packer.sv
// Big-endian byte-to-word packer shared by the header and the data words.
// word_next is the word that would complete if the current byte is the
// fourth one; word/word_valid are registered and only updated for words
// the caller marks with emit, so header words never reach the memory port.
module byte_packer
    import mips_boot_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    input  logic        emit,
    output logic [1:0]  cnt,
    output logic [31:0] word_next,
    output logic        word_valid,
    output logic [31:0] word
);

    localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

    logic [23:0] shift_r;
    logic [1:0]  cnt_r;
    logic        word_valid_r;
    logic [31:0] word_r;

    assign word_next  = {shift_r, in_data};
    assign cnt        = cnt_r;
    assign word_valid = word_valid_r;
    assign word       = word_r;

    // Shift accepted bytes in MSB first and emit a one-cycle strobe per word.
    always_ff @(posedge clock) begin
        if (reset) begin
            shift_r      <= 24'd0;
            cnt_r        <= 2'd0;
            word_valid_r <= 1'b0;
            word_r       <= 32'd0;
        end else if (clear) begin
            shift_r      <= 24'd0;
            cnt_r        <= 2'd0;
            word_valid_r <= 1'b0;
        end else begin
            word_valid_r <= 1'b0;
            if (in_valid) begin
                shift_r <= word_next[23:0];
                if (cnt_r == LAST_BYTE) begin
                    cnt_r <= 2'd0;
                    if (emit) begin
                        word_valid_r <= 1'b1;
                        word_r       <= word_next;
                    end
                end else begin
                    cnt_r <= cnt_r + 2'd1;
                end
            end
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: receives a length-prefixed big-endian program over a
// valid/ready byte stream, writes it word by word into instruction memory
// from address 0 and keeps the CPU in reset until the last word is written.
module imem_boot_loader
    import mips_boot_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int CNT_W       = 9,
    parameter int TIMEOUT_CYC = 1000000
)
(
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic             rx_ready,
    output logic             imem_we,
    output logic [31:0]      imem_addr,
    output logic [31:0]      imem_wdata,
    output logic             cpu_reset,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [CNT_W-1:0] words_loaded
);

    localparam int          TMO_W   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    state_t             state_r;
    logic               rx_ready_r;
    logic [31:0]        imem_addr_r;
    logic               cpu_reset_r;
    logic               busy_r;
    logic               done_r;
    logic               error_r;
    logic [CNT_W-1:0]   words_loaded_r;
    logic [CNT_W-1:0]   total_r;
    logic [TMO_W-1:0]   tmo_r;

    logic               accept_s;
    logic               start_s;
    logic               streaming_s;
    logic               timeout_s;
    logic               clear_s;
    logic               emit_s;
    logic               hdr_done_s;
    logic               word_done_s;
    logic [CNT_W-1:0]   wl_inc_s;
    logic [1:0]         pk_cnt_s;
    logic [31:0]        pk_next_s;
    logic               pk_valid_s;
    logic [31:0]        pk_word_s;

    assign accept_s    = rx_valid && rx_ready_r;
    assign start_s     = start && ((state_r == ST_IDLE) || (state_r == ST_ERROR));
    assign streaming_s = (state_r == ST_HDR) || (state_r == ST_LOAD);
    assign timeout_s   = streaming_s && !accept_s && (tmo_r == TMO_W'(TIMEOUT_CYC - 1));
    assign clear_s     = start_s || timeout_s;
    assign emit_s      = (state_r == ST_LOAD);
    assign hdr_done_s  = accept_s && (pk_cnt_s == 2'(HDR_BYTES - 1));
    assign word_done_s = accept_s && (pk_cnt_s == 2'(BYTES_PER_WORD - 1));
    assign wl_inc_s    = words_loaded_r + CNT_W'(1);

    byte_packer u_packer (
        .clock      (clock),
        .reset      (reset),
        .clear      (clear_s),
        .in_valid   (accept_s),
        .in_data    (rx_data),
        .emit       (emit_s),
        .cnt        (pk_cnt_s),
        .word_next  (pk_next_s),
        .word_valid (pk_valid_s),
        .word       (pk_word_s)
    );

    assign rx_ready     = rx_ready_r;
    assign imem_we      = pk_valid_s;
    assign imem_addr    = imem_addr_r;
    assign imem_wdata   = pk_word_s;
    assign cpu_reset    = cpu_reset_r;
    assign busy         = busy_r;
    assign done         = done_r;
    assign error        = error_r;
    assign words_loaded = words_loaded_r;

    // Load sequencer: state, registered status outputs, address and timeout.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r        <= ST_IDLE;
            rx_ready_r     <= 1'b0;
            imem_addr_r    <= 32'd0;
            cpu_reset_r    <= 1'b1;
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
            error_r        <= 1'b0;
            words_loaded_r <= '0;
            total_r        <= '0;
            tmo_r          <= '0;
        end else begin
            case (state_r)
                ST_IDLE, ST_ERROR: begin
                    if (start_s) begin
                        state_r        <= ST_HDR;
                        rx_ready_r     <= 1'b1;
                        busy_r         <= 1'b1;
                        error_r        <= 1'b0;
                        words_loaded_r <= '0;
                        total_r        <= '0;
                        tmo_r          <= '0;
                    end
                end
                ST_HDR: begin
                    if (accept_s) begin
                        tmo_r <= '0;
                        if (hdr_done_s) begin
                            if (pk_next_s == 32'd0) begin
                                state_r     <= ST_DONE;
                                rx_ready_r  <= 1'b0;
                                busy_r      <= 1'b0;
                                done_r      <= 1'b1;
                                cpu_reset_r <= 1'b0;
                            end else if (pk_next_s > DEPTH_W) begin
                                state_r    <= ST_ERROR;
                                rx_ready_r <= 1'b0;
                                busy_r     <= 1'b0;
                                error_r    <= 1'b1;
                            end else begin
                                state_r <= ST_LOAD;
                                total_r <= pk_next_s[CNT_W-1:0];
                            end
                        end
                    end else if (timeout_s) begin
                        state_r    <= ST_ERROR;
                        rx_ready_r <= 1'b0;
                        busy_r     <= 1'b0;
                        error_r    <= 1'b1;
                    end else begin
                        tmo_r <= tmo_r + TMO_W'(1);
                    end
                end
                ST_LOAD: begin
                    if (accept_s) begin
                        tmo_r <= '0;
                        if (word_done_s) begin
                            imem_addr_r    <= 32'(words_loaded_r) << ADDR_SHIFT;
                            words_loaded_r <= wl_inc_s;
                            if (wl_inc_s == total_r) begin
                                state_r    <= ST_FLUSH;
                                rx_ready_r <= 1'b0;
                            end
                        end
                    end else if (timeout_s) begin
                        state_r    <= ST_ERROR;
                        rx_ready_r <= 1'b0;
                        busy_r     <= 1'b0;
                        error_r    <= 1'b1;
                    end else begin
                        tmo_r <= tmo_r + TMO_W'(1);
                    end
                end
                ST_FLUSH: begin
                    // The last write is on the port this cycle; release the
                    // CPU only from the following cycle on.
                    state_r     <= ST_DONE;
                    busy_r      <= 1'b0;
                    done_r      <= 1'b1;
                    cpu_reset_r <= 1'b0;
                end
                ST_DONE: begin
                    state_r <= ST_DONE;
                end
                default: begin
                    state_r    <= ST_IDLE;
                    rx_ready_r <= 1'b0;
                    busy_r     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: a table of complete load
// scenarios plus hand-written cycle-accurate sequences.
module tb_imem_boot_loader;

    localparam int CNT_W = 9;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [7:0]       rx_data = 8'h00;
    logic             rx_valid = 1'b0;
    logic             rx_ready;
    logic             imem_we;
    logic [31:0]      imem_addr;
    logic [31:0]      imem_wdata;
    logic             cpu_reset;
    logic             busy;
    logic             done;
    logic             error;
    logic [CNT_W-1:0] words_loaded;

    imem_boot_loader #(.DEPTH(256), .CNT_W(CNT_W), .TIMEOUT_CYC(16)) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .cpu_reset    (cpu_reset),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];

    // Log every memory write, sampled mid-cycle.
    always @(negedge clock) begin
        if (imem_we === 1'b1) begin
            wr_addr_q.push_back(imem_addr);
            wr_data_q.push_back(imem_wdata);
        end
    end

    typedef struct {
        string        name;
        logic [127:0] bytes;
        int           nbytes;
        int           gap_max;
        bit           exp_done;
        bit           exp_error;
        int           exp_words;
        int           exp_nwr;
        logic [95:0]  exp_data;
    } vec_t;

    localparam int NV = 6;
    vec_t vecs[NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        start    = 1'b0;
        rx_valid = 1'b0;
        step();
        reset = 1'b0;
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Optional idle gap, then present b until it is accepted.
    task automatic send_byte(input logic [7:0] b, input int gap);
        bit acc;
        int budget;
        for (int g = 0; g < gap; g++) begin
            rx_valid = 1'b0;
            step();
        end
        rx_valid = 1'b1;
        rx_data  = b;
        acc      = 1'b0;
        budget   = 0;
        while (!acc && budget < 50) begin
            acc = rx_ready;
            step();
            budget++;
        end
        chk("byte_accept", 32'(acc), 32'd1);
    endtask

    task automatic send_bytes(input logic [127:0] bytes, input int first, input int n);
        for (int i = first; i < first + n; i++) begin
            send_byte(bytes[127 - 8*i -: 8], 0);
        end
    endtask

    task automatic wait_end(input int budget);
        int c;
        c = 0;
        while (!(done || error) && c < budget) begin
            step();
            c++;
        end
        chk("end_wait", 32'(done || error), 32'd1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rx_ready"},  32'(rx_ready),     32'd0);
        chk({tag, "_imem_we"},   32'(imem_we),      32'd0);
        chk({tag, "_imem_addr"}, imem_addr,         32'd0);
        chk({tag, "_wdata"},     imem_wdata,        32'd0);
        chk({tag, "_cpu_reset"}, 32'(cpu_reset),    32'd1);
        chk({tag, "_busy"},      32'(busy),         32'd0);
        chk({tag, "_done"},      32'(done),         32'd0);
        chk({tag, "_error"},     32'(error),        32'd0);
        chk({tag, "_words"},     32'(words_loaded), 32'd0);
    endtask

    logic [127:0] s1;

    initial begin
        s1 = {32'h00000002, 32'h20080005, 32'h01095020, 32'h0};
        vecs[0] = '{"n2_nogap",  s1, 12, 0,  1'b1, 1'b0, 2, 2, {32'h20080005, 32'h01095020, 32'h0}};
        vecs[1] = '{"n2_gaps",   s1, 12, 10, 1'b1, 1'b0, 2, 2, {32'h20080005, 32'h01095020, 32'h0}};
        vecs[2] = '{"n0",        {32'h00000000, 96'h0}, 4, 0, 1'b1, 1'b0, 0, 0, 96'h0};
        vecs[3] = '{"n257",      {32'h00000101, 96'h0}, 4, 3, 1'b0, 1'b1, 0, 0, 96'h0};
        vecs[4] = '{"nhuge",     {32'h80000001, 96'h0}, 4, 0, 1'b0, 1'b1, 0, 0, 96'h0};
        vecs[5] = '{"n3_gaps",   {32'h00000003, 32'hDEADBEEF, 32'h00000000, 32'hFFFFFFFF},
                    16, 10, 1'b1, 1'b0, 3, 3, {32'hDEADBEEF, 32'h00000000, 32'hFFFFFFFF}};

        // Reset state.
        do_reset();
        chk_reset_vals("reset");

        // Table-driven complete loads.
        for (int v = 0; v < NV; v++) begin
            do_reset();
            pulse_start();
            chk({vecs[v].name, "_busy"}, 32'(busy), 32'd1);
            for (int i = 0; i < vecs[v].nbytes; i++) begin
                send_byte(vecs[v].bytes[127 - 8*i -: 8], $urandom_range(vecs[v].gap_max, 0));
            end
            rx_valid = 1'b0;
            wait_end(40);
            step();
            chk({vecs[v].name, "_done"},      32'(done),         32'(vecs[v].exp_done));
            chk({vecs[v].name, "_error"},     32'(error),        32'(vecs[v].exp_error));
            chk({vecs[v].name, "_cpu_reset"}, 32'(cpu_reset),    32'(!vecs[v].exp_done));
            chk({vecs[v].name, "_busy_end"},  32'(busy),         32'd0);
            chk({vecs[v].name, "_words"},     32'(words_loaded), 32'(vecs[v].exp_words));
            chk({vecs[v].name, "_nwr"},       32'(wr_addr_q.size()), 32'(vecs[v].exp_nwr));
            for (int j = 0; j < vecs[v].exp_nwr && j < wr_addr_q.size(); j++) begin
                chk($sformatf("%s_addr%0d", vecs[v].name, j), wr_addr_q[j], 32'(j * 4));
                chk($sformatf("%s_data%0d", vecs[v].name, j), wr_data_q[j],
                    vecs[v].exp_data[95 - 32*j -: 32]);
            end
        end

        // Cycle-accurate normal load; valid bytes before start are ignored.
        do_reset();
        rx_valid = 1'b1;
        rx_data  = 8'hAA;
        step();
        step();
        chk("idle_rx_ready", 32'(rx_ready), 32'd0);
        pulse_start();
        send_bytes(s1, 0, 8);
        chk("t1_we0",    32'(imem_we),      32'd1);
        chk("t1_addr0",  imem_addr,         32'h0);
        chk("t1_data0",  imem_wdata,        32'h20080005);
        chk("t1_words0", 32'(words_loaded), 32'd1);
        send_bytes(s1, 8, 4);
        rx_valid = 1'b0;
        chk("t1_we1",    32'(imem_we),      32'd1);
        chk("t1_addr1",  imem_addr,         32'h4);
        chk("t1_data1",  imem_wdata,        32'h01095020);
        chk("t1_words1", 32'(words_loaded), 32'd2);
        chk("t1_flush_rdy",  32'(rx_ready),  32'd0);
        chk("t1_flush_cpu",  32'(cpu_reset), 32'd1);
        chk("t1_flush_done", 32'(done),      32'd0);
        step();
        chk("t1_done",      32'(done),      32'd1);
        chk("t1_cpu_rel",   32'(cpu_reset), 32'd0);
        chk("t1_we_off",    32'(imem_we),   32'd0);
        pulse_start();
        chk("t1_start_ign", 32'(busy),      32'd0);
        chk("t1_done_hold", 32'(done),      32'd1);
        chk("t1_nwr",       32'(wr_addr_q.size()), 32'd2);

        // Header N=0 completes one cycle after the fourth header byte.
        do_reset();
        pulse_start();
        send_bytes({32'h0, 96'h0}, 0, 4);
        rx_valid = 1'b0;
        chk("t2_done",  32'(done),      32'd1);
        chk("t2_cpu",   32'(cpu_reset), 32'd0);
        chk("t2_words", 32'(words_loaded), 32'd0);
        chk("t2_nwr",   32'(wr_addr_q.size()), 32'd0);

        // Oversized header then a valid reload from ERROR.
        do_reset();
        pulse_start();
        send_bytes({32'h00000101, 96'h0}, 0, 4);
        rx_valid = 1'b0;
        chk("t3_error", 32'(error),     32'd1);
        chk("t3_cpu",   32'(cpu_reset), 32'd1);
        pulse_start();
        chk("t3_rerr",  32'(error),     32'd0);
        chk("t3_rbusy", 32'(busy),      32'd1);
        send_bytes({32'h00000001, 32'hCAFEF00D, 64'h0}, 0, 8);
        rx_valid = 1'b0;
        wait_end(10);
        chk("t3_done",  32'(done),  32'd1);
        chk("t3_err2",  32'(error), 32'd0);
        chk("t3_nwr",   32'(wr_addr_q.size()), 32'd1);
        if (wr_data_q.size() > 0) chk("t3_data", wr_data_q[0], 32'hCAFEF00D);

        // Timeout after a partial word: exactly 16 idle cycles.
        do_reset();
        pulse_start();
        send_bytes({32'h00000001, 32'h11223344, 64'h0}, 0, 6);
        rx_valid = 1'b0;
        repeat (15) step();
        chk("t5_err_early", 32'(error), 32'd0);
        step();
        chk("t5_error", 32'(error),     32'd1);
        chk("t5_cpu",   32'(cpu_reset), 32'd1);
        chk("t5_busy",  32'(busy),      32'd0);
        chk("t5_rdy",   32'(rx_ready),  32'd0);
        step();
        chk("t5_nwr",   32'(wr_addr_q.size()), 32'd0);

        // Reset mid-load, then a full fresh load.
        do_reset();
        pulse_start();
        send_bytes({32'h00000003, 32'h0A0B0C0D, 64'h0}, 0, 8);
        reset    = 1'b1;
        rx_valid = 1'b0;
        step();
        chk_reset_vals("t6_rst");
        reset = 1'b0;
        wr_addr_q.delete();
        wr_data_q.delete();
        pulse_start();
        send_bytes({32'h00000003, 32'h0A0B0C0D, 32'h01020304, 32'hF0E0D0C0}, 0, 16);
        rx_valid = 1'b0;
        wait_end(10);
        chk("t6_done",  32'(done),         32'd1);
        chk("t6_words", 32'(words_loaded), 32'd3);
        chk("t6_nwr",   32'(wr_addr_q.size()), 32'd3);
        for (int j = 0; j < 3 && j < wr_addr_q.size(); j++) begin
            chk($sformatf("t6_addr%0d", j), wr_addr_q[j], 32'(j * 4));
        end
        if (wr_data_q.size() == 3) chk("t6_data2", wr_data_q[2], 32'hF0E0D0C0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
